// File: rtl/vga_fetch_pkg.sv
// vga_fetch_pkg: shared FSM states, beat size and RGB565 helpers for the framebuffer fetcher
package vga_fetch_pkg;
  typedef enum logic [2:0] {ST_IDLE, ST_WAIT, ST_ADDR, ST_DATA, ST_DRAIN} state_e;
  localparam int BEAT_BYTES = 4;
  typedef struct packed {
    logic [4:0] r;
    logic [5:0] g;
    logic [4:0] b;
  } rgb565_t;
  function automatic logic [15:0] rgb565_pack(input rgb565_t p);
    return {p.r, p.g, p.b};
  endfunction
  function automatic rgb565_t rgb565_unpack(input logic [15:0] w);
    return rgb565_t'(w);
  endfunction
endpackage

// File: rtl/vga_fb_fifo.sv
// vga_fb_fifo: synchronous pixel-word FIFO with flush; head is visible the cycle after it is written
module vga_fb_fifo #(
  parameter int DEPTH = 64,
  parameter int W = 32,
  parameter int CW = $clog2(DEPTH) + 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          flush_i,
  input  logic          push_i,
  input  logic [W-1:0]  data_i,
  input  logic          pop_i,
  output logic [W-1:0]  data_o,
  output logic [CW-1:0] count_o,
  output logic          full_o,
  output logic          empty_o
);
  localparam int AW = CW - 1;
  logic [W-1:0] mem_q [DEPTH];
  logic [AW-1:0] rd_q, wr_q;
  logic [CW-1:0] cnt_q;
  logic do_push, do_pop;
  assign empty_o = cnt_q == '0;
  assign full_o = cnt_q == CW'(DEPTH);
  assign count_o = cnt_q;
  assign do_pop = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);
  assign data_o = empty_o ? '0 : mem_q[rd_q];
  // storage write; a push into a full FIFO only lands when the head leaves in the same cycle
  always_ff @(posedge clk_i)
    if (do_push && !flush_i) mem_q[wr_q] <= data_i;
  // pointers and occupancy; flush wins over any push or pop in the same cycle
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      rd_q <= '0;
      wr_q <= '0;
      cnt_q <= '0;
    end else if (flush_i) begin
      rd_q <= '0;
      wr_q <= '0;
      cnt_q <= '0;
    end else begin
      rd_q <= rd_q + AW'(do_pop);
      wr_q <= wr_q + AW'(do_push);
      cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
    end
endmodule

// File: rtl/vga_fb_fetch.sv
// vga_fb_fetch: AXI4 burst reader streaming a framebuffer into a pixel-word FIFO
module vga_fb_fetch
  import vga_fetch_pkg::*;
#(
  parameter int AXI_ADDR_W = 32,
  parameter int AXI_DATA_W = 32,
  parameter int BURST_LEN = 16,
  parameter int FIFO_DEPTH = 64
) (
  input  logic                  pclk_i,
  input  logic                  prst_i,
  input  logic                  en_i,
  input  logic [AXI_ADDR_W-1:0] fb_base_i,
  input  logic [19:0]           frame_words_i,
  input  logic                  frame_start_i,
  output logic                  ar_valid_o,
  input  logic                  ar_ready_i,
  output logic [AXI_ADDR_W-1:0] ar_addr_o,
  output logic [7:0]            ar_len_o,
  input  logic                  r_valid_i,
  output logic                  r_ready_o,
  input  logic [AXI_DATA_W-1:0] r_data_i,
  input  logic                  r_last_i,
  input  logic [1:0]            r_resp_i,
  input  logic                  pix_rd_i,
  output logic [AXI_DATA_W-1:0] pix_data_o,
  output logic                  pix_valid_o,
  output logic                  busy_o,
  output logic                  underflow_o,
  output logic                  rerr_o
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  state_e state_q, state_d;
  logic [AXI_ADDR_W-1:0] addr_q, addr_d;
  logic [19:0] rem_q, rem_d, beats;
  logic restart_q, restart_d, drain_q, drain_d, en_q, uf_q, uf_d, rerr_q, rerr_d;
  logic flush, push, en_rise, in_flight, fifo_full, fifo_empty;
  logic [CW-1:0] fifo_cnt;
  assign beats = rem_q > 20'(BURST_LEN) ? 20'(BURST_LEN) : rem_q;
  assign ar_addr_o = addr_q;
  assign ar_len_o = 8'(beats - 20'd1);
  assign busy_o = state_q == ST_ADDR || state_q == ST_DATA;
  assign in_flight = busy_o || state_q == ST_WAIT;
  assign pix_valid_o = ~fifo_empty;
  assign underflow_o = uf_q;
  assign rerr_o = rerr_q;
  assign en_rise = en_i & ~en_q;
  assign uf_d = (en_rise ? 1'b0 : uf_q) | (pix_rd_i & fifo_empty);
  assign rerr_d = (en_rise ? 1'b0 : rerr_q) | (r_valid_i & r_ready_o & (r_resp_i != 2'd0));

  vga_fb_fifo #(.DEPTH(FIFO_DEPTH), .W(AXI_DATA_W), .CW(CW)) u_fifo (
    .clk_i(pclk_i), .rst_i(prst_i), .flush_i(flush), .push_i(push), .data_i(r_data_i),
    .pop_i(pix_rd_i), .data_o(pix_data_o), .count_o(fifo_cnt), .full_o(fifo_full), .empty_o(fifo_empty)
  );

  // next-state: one burst at a time; restarts and disables wait for the in-flight burst to end
  always_comb begin
    state_d = state_q;
    addr_d = addr_q;
    rem_d = rem_q;
    restart_d = restart_q | (frame_start_i & in_flight);
    drain_d = drain_q | (~en_i & busy_o);
    flush = 1'b0;
    push = 1'b0;
    ar_valid_o = 1'b0;
    r_ready_o = 1'b0;
    case (state_q)
      ST_IDLE: begin
        restart_d = 1'b0;
        drain_d = 1'b0;
        flush = ~en_i;
        if (en_i && frame_start_i && frame_words_i != '0) begin
          addr_d = fb_base_i;
          rem_d = frame_words_i;
          flush = 1'b1;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (!en_i) begin
          flush = 1'b1;
          state_d = ST_IDLE;
        end else if (restart_d) begin
          restart_d = 1'b0;
          addr_d = fb_base_i;
          rem_d = frame_words_i;
          flush = 1'b1;
          state_d = frame_words_i != '0 ? ST_WAIT : ST_IDLE;
        end else if (rem_q == '0) begin
          state_d = ST_IDLE;
        end else if (!fifo_full && fifo_cnt <= CW'(FIFO_DEPTH - BURST_LEN)) begin
          state_d = ST_ADDR;
        end
      end
      ST_ADDR: begin
        ar_valid_o = 1'b1;
        if (ar_ready_i) state_d = ST_DATA;
      end
      ST_DATA: begin
        r_ready_o = 1'b1;
        if (!en_i || drain_q) begin
          flush = r_valid_i & r_last_i;
          state_d = (r_valid_i && r_last_i) ? ST_IDLE : ST_DRAIN;
        end else begin
          push = r_valid_i;
          if (r_valid_i && r_last_i && restart_d) begin
            restart_d = 1'b0;
            addr_d = fb_base_i;
            rem_d = frame_words_i;
            flush = 1'b1;
            state_d = frame_words_i != '0 ? ST_WAIT : ST_IDLE;
          end else if (r_valid_i && r_last_i) begin
            addr_d = addr_q + AXI_ADDR_W'(beats) * AXI_ADDR_W'(BEAT_BYTES);
            rem_d = rem_q - beats;
            state_d = ST_WAIT;
          end
        end
      end
      ST_DRAIN: begin
        r_ready_o = 1'b1;
        flush = r_valid_i & r_last_i;
        if (r_valid_i && r_last_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // state and sticky flag registers; reset abandons any burst in flight
  always_ff @(posedge pclk_i or posedge prst_i)
    if (prst_i) begin
      state_q <= ST_IDLE;
      addr_q <= '0;
      rem_q <= '0;
      restart_q <= 1'b0;
      drain_q <= 1'b0;
      en_q <= 1'b0;
      uf_q <= 1'b0;
      rerr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      rem_q <= rem_d;
      restart_q <= restart_d;
      drain_q <= drain_d;
      en_q <= en_i;
      uf_q <= uf_d;
      rerr_q <= rerr_d;
    end
endmodule

// File: tb/tb_vga_fb_fetch.sv
// tb_vga_fb_fetch: directed self-checking bench for the framebuffer fetcher
module tb_vga_fb_fetch;
  logic pclk_i = 1'b0, prst_i = 1'b1, en_i = 1'b0, frame_start_i = 1'b0, ar_ready_i = 1'b0;
  logic r_valid_i = 1'b0, r_last_i = 1'b0, pix_rd_i = 1'b0;
  logic [31:0] fb_base_i = '0, r_data_i = '0;
  logic [19:0] frame_words_i = '0;
  logic [1:0] r_resp_i = '0;
  logic ar_valid_o, r_ready_o, pix_valid_o, busy_o, underflow_o, rerr_o;
  logic [31:0] ar_addr_o, pix_data_o;
  logic [7:0] ar_len_o;
  int checks = 0, failures = 0;
  logic first_v;
  logic [31:0] first_d;

  vga_fb_fetch dut (
    .pclk_i(pclk_i), .prst_i(prst_i), .en_i(en_i), .fb_base_i(fb_base_i), .frame_words_i(frame_words_i),
    .frame_start_i(frame_start_i), .ar_valid_o(ar_valid_o), .ar_ready_i(ar_ready_i), .ar_addr_o(ar_addr_o),
    .ar_len_o(ar_len_o), .r_valid_i(r_valid_i), .r_ready_o(r_ready_o), .r_data_i(r_data_i), .r_last_i(r_last_i),
    .r_resp_i(r_resp_i), .pix_rd_i(pix_rd_i), .pix_data_o(pix_data_o), .pix_valid_o(pix_valid_o),
    .busy_o(busy_o), .underflow_o(underflow_o), .rerr_o(rerr_o)
  );

  always #5 pclk_i = ~pclk_i;

  task automatic tick();
    @(posedge pclk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start();
    frame_start_i = 1'b1;
    tick();
    frame_start_i = 1'b0;
  endtask

  task automatic expect_ar(input string tag, input logic [31:0] a, input logic [7:0] l, input int stall);
    int n = 0;
    logic stable = 1'b1;
    while (ar_valid_o !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    chk({tag, "_valid"}, ar_valid_o, 1);
    chk({tag, "_addr"}, ar_addr_o, a);
    chk({tag, "_len"}, ar_len_o, l);
    for (int i = 0; i < stall; i++) begin
      tick();
      if (ar_valid_o !== 1'b1 || ar_addr_o !== a || ar_len_o !== l) stable = 1'b0;
    end
    if (stall > 0) chk({tag, "_stable"}, stable, 1);
    ar_ready_i = 1'b1;
    tick();
    ar_ready_i = 1'b0;
  endtask

  task automatic burst(input string tag, input int n, input logic [31:0] a0, input int resp_beat,
                       input int start_beat, input int drop_beat);
    logic rdy = 1'b1;
    for (int i = 0; i < n; i++) begin
      r_valid_i = 1'b1;
      r_data_i = a0 + 32'(4 * i);
      r_last_i = (i == n - 1);
      r_resp_i = (i == resp_beat) ? 2'd2 : 2'd0;
      frame_start_i = (i == start_beat);
      if (i == drop_beat) en_i = 1'b0;
      #1;
      if (r_ready_o !== 1'b1) rdy = 1'b0;
      tick();
      frame_start_i = 1'b0;
      if (i == 0) begin
        first_v = pix_valid_o;
        first_d = pix_data_o;
      end
    end
    r_valid_i = 1'b0;
    r_last_i = 1'b0;
    r_resp_i = 2'd0;
    chk({tag, "_rready"}, rdy, 1);
  endtask

  task automatic pop_check(input string tag, input int n, input logic [31:0] a0);
    logic ok = 1'b1;
    for (int i = 0; i < n; i++) begin
      if (pix_valid_o !== 1'b1 || pix_data_o !== a0 + 32'(4 * i)) ok = 1'b0;
      pix_rd_i = 1'b1;
      tick();
    end
    pix_rd_i = 1'b0;
    chk(tag, ok, 1);
  endtask

  task automatic no_ar(input string tag, input int n);
    logic seen = 1'b0;
    repeat (n) begin
      tick();
      if (ar_valid_o !== 1'b0) seen = 1'b1;
    end
    chk(tag, seen, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) tick();
    chk("rst_arvalid", ar_valid_o, 0);
    chk("rst_rready", r_ready_o, 0);
    chk("rst_pixvalid", pix_valid_o, 0);
    chk("rst_pixdata", pix_data_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_underflow", underflow_o, 0);
    chk("rst_rerr", rerr_o, 0);
    prst_i = 1'b0;
    tick();
    // 40-word frame: two full bursts and an 8-beat tail
    en_i = 1'b1;
    fb_base_i = 32'h8000_0000;
    frame_words_i = 20'd40;
    pulse_start();
    expect_ar("f40_ar0", 32'h8000_0000, 8'd15, 0);
    chk("f40_busy", busy_o, 1);
    chk("f40_empty_pre", pix_valid_o, 0);
    burst("f40_b0", 16, 32'h8000_0000, -1, -1, -1);
    chk("fwft_valid", first_v, 1);
    chk("fwft_data", first_d, 32'h8000_0000);
    expect_ar("f40_ar1", 32'h8000_0040, 8'd15, 0);
    burst("f40_b1", 16, 32'h8000_0040, -1, -1, -1);
    expect_ar("f40_ar2", 32'h8000_0080, 8'd7, 0);
    burst("f40_b2", 8, 32'h8000_0080, -1, -1, -1);
    no_ar("f40_done_noar", 20);
    chk("f40_idle_busy", busy_o, 0);
    pop_check("f40_data", 40, 32'h8000_0000);
    chk("f40_drained", pix_valid_o, 0);
    chk("f40_no_underflow", underflow_o, 0);
    // back-pressure: FIFO fills with 64 words, refetch only once 16 slots free
    fb_base_i = 32'h0000_1000;
    frame_words_i = 20'd100;
    pulse_start();
    for (int b = 0; b < 4; b++) begin
      expect_ar("bp_ar", 32'h0000_1000 + 32'(b * 64), 8'd15, 0);
      burst("bp_b", 16, 32'h0000_1000 + 32'(b * 64), -1, -1, -1);
    end
    no_ar("bp_full_noar", 30);
    pop_check("bp_pop15", 15, 32'h0000_1000);
    no_ar("bp_49_noar", 10);
    pop_check("bp_pop16th", 1, 32'h0000_103C);
    // AR held under ar_ready low for 10 cycles
    expect_ar("stall_ar", 32'h0000_1100, 8'd15, 10);
    burst("stall_b", 16, 32'h0000_1100, -1, -1, -1);
    // restart mid-burst at beat 5
    pop_check("rs_pop", 16, 32'h0000_1040);
    fb_base_i = 32'h0000_2000;
    frame_words_i = 20'd32;
    expect_ar("rs_ar_old", 32'h0000_1140, 8'd15, 0);
    burst("rs_b", 16, 32'h0000_1140, -1, 4, -1);
    chk("rs_flushed", pix_valid_o, 0);
    expect_ar("rs_ar_new", 32'h0000_2000, 8'd15, 0);
    // disable mid-burst: remaining beats are drained and discarded
    burst("dis_b", 16, 32'h0000_2000, -1, -1, 3);
    chk("dis_flushed", pix_valid_o, 0);
    chk("dis_busy", busy_o, 0);
    no_ar("dis_noar", 20);
    chk("dis_rerr_clear", rerr_o, 0);
    // underflow on empty pop, cleared only by the enable edge
    pix_rd_i = 1'b1;
    #1;
    chk("uf_data", pix_data_o, 0);
    tick();
    pix_rd_i = 1'b0;
    chk("uf_set", underflow_o, 1);
    repeat (5) tick();
    chk("uf_sticky", underflow_o, 1);
    en_i = 1'b1;
    tick();
    chk("uf_cleared", underflow_o, 0);
    // read error on one beat; beat still stored
    fb_base_i = 32'h0000_3000;
    frame_words_i = 20'd16;
    pulse_start();
    expect_ar("re_ar", 32'h0000_3000, 8'd15, 0);
    burst("re_b", 16, 32'h0000_3000, 2, -1, -1);
    chk("re_set", rerr_o, 1);
    pop_check("re_data", 16, 32'h0000_3000);
    chk("re_empty", pix_valid_o, 0);
    en_i = 1'b0;
    tick();
    chk("re_sticky", rerr_o, 1);
    en_i = 1'b1;
    tick();
    chk("re_cleared", rerr_o, 0);
    // zero-length frame fetches nothing
    frame_words_i = 20'd0;
    pulse_start();
    no_ar("zero_noar", 20);
    chk("zero_busy", busy_o, 0);
    // asynchronous reset in the middle of a burst
    fb_base_i = 32'h0000_4000;
    frame_words_i = 20'd32;
    pulse_start();
    expect_ar("ar_rst", 32'h0000_4000, 8'd15, 0);
    r_valid_i = 1'b1;
    r_data_i = 32'h0000_00AA;
    repeat (3) tick();
    chk("mid_pixvalid", pix_valid_o, 1);
    #2;
    prst_i = 1'b1;
    #1;
    chk("arst_busy", busy_o, 0);
    chk("arst_rready", r_ready_o, 0);
    chk("arst_pixvalid", pix_valid_o, 0);
    chk("arst_pixdata", pix_data_o, 0);
    r_valid_i = 1'b0;
    tick();
    prst_i = 1'b0;
    no_ar("arst_noar", 10);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
